// File: rtl/apb_timer_irq_pkg.sv
// ---------------------------------------------------------------------------
// apb_timer_irq_pkg
// Shared constants for the timer interrupt controller: register word offsets
// (decoded from PADDR[4:2]), the bit position of the "interrupt valid" flag in
// the ID register, and the width of the interrupt ID field.
// ---------------------------------------------------------------------------
package apb_timer_irq_pkg;

  localparam int IRQ_ID_W     = 5;
  localparam int ID_VALID_BIT = 31;

  // Word offsets (byte offset = word offset * 4)
  localparam logic [2:0] OFF_PENDING     = 3'd0;  // 0x00 RW1C
  localparam logic [2:0] OFF_MASK        = 3'd1;  // 0x04 RW
  localparam logic [2:0] OFF_PENDING_SET = 3'd2;  // 0x08 WO
  localparam logic [2:0] OFF_ACTIVE      = 3'd3;  // 0x0C RO
  localparam logic [2:0] OFF_ID          = 3'd4;  // 0x10 RO

  // Offsets above OFF_ID are unmapped and answer with PSLVERR.
  function automatic logic is_unmapped(input logic [2:0] off);
    return off > OFF_ID;
  endfunction

endpackage

// File: rtl/apb_timer_irq_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-first priority encoder. Reusable by any interrupt aggregator.
//   vec_i   [N-1:0]    request vector
//   valid_o            at least one request set
//   id_o    [ID_W-1:0] index of the lowest set bit, 0 when none set
// ---------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 5
) (
  input  logic [N-1:0]    vec_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  assign valid_o = |vec_i;

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/apb_timer_irq_ctrl.sv
// ---------------------------------------------------------------------------
// apb_timer_irq_ctrl
// Collects the timer block's interrupt pulses/levels, edge-detects each into
// a sticky pending bit, masks them, and presents one prioritised interrupt
// (lowest index first) with an ID and acknowledge handshake to the core.
// Zero-wait-state APB slave for PENDING / MASK / PENDING_SET / ACTIVE / ID.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/   APB slave; only PADDR[4:2] is decoded
//   PSEL/PENABLE
//   PRDATA/PREADY/PSLVERR  APB response (PREADY tied high)
//   irq_i   [IRQ_CNT-1:0]  interrupt sources
//   irq_o                  combined interrupt request
//   irq_id_o [4:0]         index of presented source
//   irq_ack_i              one-cycle acknowledge of the presented source
// ---------------------------------------------------------------------------
module apb_timer_irq_ctrl
  import apb_timer_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int IRQ_CNT        = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [IRQ_CNT-1:0]        irq_i,
  output logic                      irq_o,
  output logic [IRQ_ID_W-1:0]       irq_id_o,
  input  logic                      irq_ack_i
);

  logic [IRQ_CNT-1:0] irq_q;
  logic [IRQ_CNT-1:0] pending;
  logic [IRQ_CNT-1:0] mask;
  logic [IRQ_CNT-1:0] active;
  logic [IRQ_CNT-1:0] rise;
  logic [IRQ_CNT-1:0] wdata_irq;
  logic [IRQ_CNT-1:0] ack_vec;
  logic [IRQ_CNT-1:0] set_vec;
  logic [IRQ_CNT-1:0] clr_vec;

  logic [2:0]  reg_off;
  logic        bad_off;
  logic        apb_access;
  logic        apb_wr;
  logic        apb_rd;
  logic        wr_pending;
  logic        wr_mask;
  logic        wr_pending_set;
  logic [31:0] rd_data;
  logic        unused_ok;

  // Address bits outside [4:2] and write-data bits above IRQ_CNT are don't-care.
  assign unused_ok = ^{PADDR, PWDATA};

  // ---------------------------------------------------------------- APB decode
  assign reg_off    = PADDR[4:2];
  assign bad_off    = is_unmapped(reg_off);
  assign apb_access = PSEL & PENABLE;
  assign apb_wr     = apb_access & PWRITE & ~bad_off;
  assign apb_rd     = PSEL & ~PWRITE;

  assign wr_pending     = apb_wr & (reg_off == OFF_PENDING);
  assign wr_mask        = apb_wr & (reg_off == OFF_MASK);
  assign wr_pending_set = apb_wr & (reg_off == OFF_PENDING_SET);

  assign wdata_irq = PWDATA[IRQ_CNT-1:0];

  assign PREADY  = 1'b1;
  assign PSLVERR = apb_access & bad_off;

  // ------------------------------------------------------- source/priority
  assign rise   = irq_i & ~irq_q;
  assign active = pending & mask;

  irq_prio_enc #(
    .N   (IRQ_CNT),
    .ID_W(IRQ_ID_W)
  ) u_prio_enc (
    .vec_i  (active),
    .valid_o(irq_o),
    .id_o   (irq_id_o)
  );

  // Acknowledge only retires the source currently being presented.
  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      ack_vec[i] = irq_ack_i & irq_o & (irq_id_o == IRQ_ID_W'(i));
    end
  end

  assign set_vec = rise | (wr_pending_set ? wdata_irq : '0);
  assign clr_vec = ack_vec | (wr_pending ? wdata_irq : '0);

  // --------------------------------------------------------------- state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_q   <= irq_i;
      // A new event in the same cycle as a clear keeps the bit pending.
      pending <= (pending & ~clr_vec) | set_vec;
      if (wr_mask) mask <= wdata_irq;
    end
  end

  // --------------------------------------------------------------- readback
  always_comb begin
    rd_data = '0;
    if (apb_rd) begin
      case (reg_off)
        OFF_PENDING: rd_data = 32'(pending);
        OFF_MASK:    rd_data = 32'(mask);
        OFF_ACTIVE:  rd_data = 32'(active);
        OFF_ID: begin
          rd_data[ID_VALID_BIT]  = irq_o;
          rd_data[IRQ_ID_W-1:0]  = irq_id_o;
        end
        default:     rd_data = '0;
      endcase
    end
  end

  assign PRDATA = rd_data;

endmodule

// File: tb/tb_apb_timer_irq_ctrl.sv
module tb_apb_timer_irq_ctrl;

  localparam int AW = 12;
  localparam int N  = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic          PWRITE = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [N-1:0]  irq_i = '0;
  logic          irq_o;
  logic [4:0]    irq_id_o;
  logic          irq_ack_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  apb_timer_irq_ctrl #(.APB_ADDR_WIDTH(AW), .IRQ_CNT(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_i(irq_i), .irq_o(irq_o),
    .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [31:0] m_pending, m_mask, m_prev;
  logic [31:0] mv_cur, mv_act, mv_set, mv_clr, mv_wd;
  logic [2:0]  mv_off;
  logic        mv_wr;
  logic [31:0] m_all = 32'((64'd1 << N) - 1);

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    logic [31:0] act;
    act = m_pending & m_mask;
    case (off)
      3'd0: return m_pending;
      3'd1: return m_mask;
      3'd3: return act;
      3'd4: return {(act != 0), 26'b0, 5'(lowest(act))};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_pending = 0;
      m_mask    = 0;
      m_prev    = 0;
    end else begin
      mv_cur = 32'(irq_i);
      mv_act = m_pending & m_mask;
      mv_wd  = PWDATA & m_all;
      mv_off = PADDR[4:2];
      mv_wr  = PSEL && PENABLE && PWRITE;
      mv_set = mv_cur & ~m_prev;
      mv_clr = 0;
      if (mv_wr && mv_off == 3'd2) mv_set = mv_set | mv_wd;
      if (mv_wr && mv_off == 3'd0) mv_clr = mv_clr | mv_wd;
      if (irq_ack_i && mv_act != 0) mv_clr[lowest(mv_act)] = 1'b1;
      m_pending = ((m_pending & ~mv_clr) | mv_set) & m_all;
      if (mv_wr && mv_off == 3'd1) m_mask = mv_wd;
      m_prev = mv_cur;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("irq_o", 32'(irq_o), 32'((m_pending & m_mask) != 0));
      chk("irq_id", 32'(irq_id_o), 32'(lowest(m_pending & m_mask)));
      chk("pready", 32'(PREADY), 32'd1);
      chk("pslverr", 32'(PSLVERR), 32'(PSEL && PENABLE && (PADDR[4:2] >= 3'd5)));
      if (PSEL && !PWRITE) chk("prdata", PRDATA, model_read(PADDR[4:2]));
      else                 chk("prdata_idle", PRDATA, 32'h0);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    tick();
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr[AW-1:0]; PWDATA = data;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    tick();
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr[AW-1:0];
    tick();
    PENABLE = 1'b1;
    #3;
    data = PRDATA;
    err  = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    #23 HRESETn = 1'b1;

    // Reset state: every register reads zero
    for (int a = 0; a < 5; a++) begin
      apb_read(32'(a * 4), rd, er);
      chk("reset_read", rd, 32'h0);
    end
    chk("reset_irq_o", 32'(irq_o), 32'h0);
    chk("reset_pready", 32'(PREADY), 32'h1);

    // Single pulse on source 2
    apb_write(32'h04, 32'hF);
    tick(); irq_i = 4'b0100;
    tick(); irq_i = 4'b0000;
    chk("pulse_irq_o", 32'(irq_o), 32'h1);
    chk("pulse_id", 32'(irq_id_o), 32'h2);
    apb_read(32'h00, rd, er);
    chk("pulse_pending", rd, 32'h4);

    // Held level gives only one event
    apb_write(32'h00, 32'h4);
    tick(); irq_i = 4'b0100;
    repeat (10) tick();
    apb_read(32'h00, rd, er);
    chk("level_pending", rd, 32'h4);
    apb_write(32'h00, 32'h4);
    apb_read(32'h00, rd, er);
    chk("level_no_reevent", rd, 32'h0);
    irq_i = 4'b0000;
    tick();

    // Priority and acknowledge
    apb_write(32'h08, 32'h6);
    chk("prio_id1", 32'(irq_id_o), 32'h1);
    tick(); irq_ack_i = 1'b1;
    tick(); irq_ack_i = 1'b0;
    chk("ack1_id2", 32'(irq_id_o), 32'h2);
    chk("ack1_irq_o", 32'(irq_o), 32'h1);
    apb_read(32'h00, rd, er);
    chk("ack1_pending", rd, 32'h4);
    tick(); irq_ack_i = 1'b1;
    tick(); irq_ack_i = 1'b0;
    chk("ack2_irq_o", 32'(irq_o), 32'h0);
    tick(); irq_ack_i = 1'b1;
    tick(); irq_ack_i = 1'b0;
    apb_read(32'h00, rd, er);
    chk("extra_ack_pending", rd, 32'h0);

    // Masked source stays pending, unmask presents it
    apb_write(32'h04, 32'h0);
    tick(); irq_i = 4'b1000;
    tick(); irq_i = 4'b0000;
    apb_read(32'h00, rd, er);
    chk("masked_pending", rd, 32'h8);
    chk("masked_irq_o", 32'(irq_o), 32'h0);
    apb_read(32'h0C, rd, er);
    chk("masked_active", rd, 32'h0);
    apb_write(32'h04, 32'h8);
    chk("unmask_irq_o", 32'(irq_o), 32'h1);
    apb_read(32'h10, rd, er);
    chk("unmask_id_reg", rd, 32'h8000_0003);
    apb_write(32'h00, 32'h8);
    apb_write(32'h04, 32'hF);

    // W1C on bit 0 coinciding with a rise on bit 0: set wins
    tick();
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = '0; PWDATA = 32'h1;
    tick();
    PENABLE = 1'b1; irq_i = 4'b0001;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; irq_i = 4'b0000;
    apb_read(32'h00, rd, er);
    chk("set_wins_w1c", rd, 32'h1);
    apb_write(32'h08, 32'h2);
    apb_read(32'h00, rd, er);
    chk("pending_set", rd, 32'h3);
    apb_write(32'h00, 32'h3);
    apb_read(32'h00, rd, er);
    chk("w1c_both", rd, 32'h0);

    // Ack coinciding with a new edge on the presented source
    apb_write(32'h08, 32'h1);
    chk("ackedge_id0", 32'(irq_id_o), 32'h0);
    tick(); irq_ack_i = 1'b1; irq_i = 4'b0001;
    tick(); irq_ack_i = 1'b0; irq_i = 4'b0000;
    apb_read(32'h00, rd, er);
    chk("ack_edge_pending", rd, 32'h1);
    apb_write(32'h00, 32'h1);

    // Unmapped offset and read-only writes
    apb_read(32'h18, rd, er);
    chk("bad_off_prdata", rd, 32'h0);
    chk("bad_off_pslverr", 32'(er), 32'h1);
    apb_write(32'h18, 32'hF);
    apb_write(32'h0C, 32'hF);
    apb_read(32'h00, rd, er);
    chk("ro_write_pending", rd, 32'h0);
    apb_read(32'h04, rd, er);
    chk("ro_write_mask", rd, 32'hF);
    chk("ro_write_pslverr", 32'(er), 32'h0);

    // Mid-operation reset
    apb_write(32'h08, 32'h5);
    chk("pre_reset_id", 32'(irq_id_o), 32'h0);
    chk("pre_reset_irq_o", 32'(irq_o), 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_irq_o", 32'(irq_o), 32'h0);
    chk("rst_irq_id", 32'(irq_id_o), 32'h0);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 12'h000;
    #1 chk("rst_pending_rd", PRDATA, 32'h0);
    PADDR = 12'h004;
    #1 chk("rst_mask_rd", PRDATA, 32'h0);
    PSEL = 1'b0;
    irq_i = 4'b0010;
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    apb_read(32'h00, rd, er);
    chk("post_reset_rise", rd, 32'h2);
    chk("post_reset_irq_o", 32'(irq_o), 32'h0);
    irq_i = 4'b0000;
    apb_read(32'h04, rd, er);
    chk("post_reset_mask", rd, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_timer_irq_ctrl.md
Name: apb_timer_irq_ctrl

Overview:
Downstream consumer of the timer block's irq_o vector (overflow/compare pulses for each timer). It edge-detects each source into a sticky pending bit and applies a per-source mask. It drives a single prioritised interrupt with ID and acknowledge handshake to the core. Software accesses pending, mask and ID through its own APB slave, decoded in the peripheral address space next to the timer.

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4KB slave)
IRQ_CNT, 4, number of interrupt sources (= 2*TIMER_CNT); legal range 1..32

Ports:
HCLK  input  1  system clock; all state on rising edge
HRESETn  input  1  asynchronous active-low reset
PADDR  input  APB_ADDR_WIDTH  APB address; only PADDR[4:2] decoded
PWDATA  input  32  APB write data
PWRITE  input  1  APB write strobe
PSEL  input  1  APB select
PENABLE  input  1  APB enable (access phase)
PRDATA  output  32  APB read data
PREADY  output  1  always 1 (zero wait states)
PSLVERR  output  1  error on undefined offset
irq_i  input  IRQ_CNT  interrupt sources from timer block (pulse or level)
irq_o  output  1  combined interrupt request to core
irq_id_o  output  5  index of highest-priority active source
irq_ack_i  input  1  single-cycle acknowledge from core

Behaviour:
- Reset: pending=0, mask=0, irq_q=0; irq_o=0, irq_id_o=0, PRDATA=0, PSLVERR=0, PREADY=1.
- Edge detect: irq_q <= irq_i every cycle; rise[i] = irq_i[i] & ~irq_q[i]. A level held high yields exactly one event; a new event needs a low cycle first.
- Registers (offset = PADDR[4:2]*4):
  - 0x00 PENDING: RW1C.
  - 0x04 MASK: RW; 1 = enabled.
  - 0x08 PENDING_SET: WO; write 1 sets the bit; reads 0.
  - 0x0C ACTIVE: RO = pending & mask.
  - 0x10 ID: RO; bit31 = irq_o, [4:0] = irq_id_o.
  - Bits >= IRQ_CNT read 0 and ignore writes.
- APB:
  - Write commits on the edge where PSEL&PENABLE&PWRITE.
  - Read data is combinational when PSEL&~PWRITE; PRDATA=0 otherwise.
  - Offsets 0x14-0x1C: PSLVERR=1 during PSEL&PENABLE, no state change, PRDATA=0.
  - Writes to RO registers are silently ignored (no error).
- Pending next state, per bit:
  - set = rise | (PENDING_SET write & PWDATA)
  - clr = (PENDING write & PWDATA) | (irq_ack_i & irq_o & id==i)
  - pending <= (pending & ~clr) | set. Set wins over clear in the same cycle.
- Output:
  - irq_o = |(pending & mask).
  - irq_id_o = lowest index with pending&mask set, or 0 if none.
  - Both are pure combinational decode of flops; no combinational path from irq_i, APB or ack.
- Latency:
  - irq_i rising before edge k gives pending set at edge k and irq_o high after edge k (1 cycle).
  - Ack at edge k clears the bit at edge k; irq_o/irq_id_o update after edge k, so the next source is presented with no bubble.
- Ack rules:
  - irq_ack_i while irq_o=0 is ignored.
  - Ack clears only the currently presented ID.
  - Ack coinciding with a new edge on the same bit leaves it pending.
- Mask: masking does not clear pending; unmasking a pending bit asserts irq_o on the next cycle.
- Mid-operation reset: all state clears asynchronously; a source high at deassertion counts as a rise one cycle later (irq_q=0).

Decomposition:
- Package apb_timer_irq_pkg: register offset localparams (PENDING, MASK, PENDING_SET, ACTIVE, ID), ID valid bit position, IRQ_ID_W=5.
- Sub-module irq_prio_enc: parameterised lowest-index-first priority encoder (vector in -> valid, id out). Reusable by other interrupt aggregators.

Test Plan:
- Reset, then read all regs -> 0 everywhere; irq_o=0; PREADY=1.
- MASK=0xF; pulse irq_i[2] for 1 cycle -> PENDING=0x4 next cycle; irq_o=1, irq_id_o=2; hold irq_i[2] high 10 cycles -> still one event.
- Pending 0x6, MASK=0xF -> irq_id_o=1; ack -> PENDING=0x4, irq_id_o=2 the next cycle; ack -> irq_o=0; extra ack -> no change.
- MASK=0x0, pulse irq_i[3] -> PENDING=0x8, irq_o=0, ACTIVE=0; write MASK=0x8 -> irq_o=1, ID reads 0x8000_0003.
- Write PENDING=0x1 in the same cycle as an irq_i[0] rise -> bit 0 remains 1; write PENDING_SET=0x2 -> PENDING bit1=1; write W1C 0x3 -> PENDING=0.
- Read offset 0x18 -> PSLVERR=1, PRDATA=0; assert HRESETn low mid-pending -> pending/mask/irq_o clear immediately.
